// File: rtl/fb_pkg.sv
// Shared definitions for the OLED frame buffer.
// The buffer is 128 columns x 8 pages, one byte per column-page,
// stored in horizontal addressing order (addr = page*128 + col).
package fb_pkg;

  localparam int FB_COLS   = 128;
  localparam int FB_PAGES  = 8;
  localparam int FB_DEPTH  = FB_COLS * FB_PAGES;
  localparam int FB_ADDR_W = $clog2(FB_DEPTH);

  // Clear/fill sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } fill_state_e;

  // Writer indices into the grant vector
  localparam int WR0 = 0;
  localparam int WR1 = 1;

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port byte RAM for the frame buffer.
// Ports:
//   clk, rst_n    clock, async active-low reset (read register only)
//   we/waddr/wdata  single write port
//   raddr/rdata     registered read port, 1-cycle latency, read-first
// The array itself is never reset. INIT_FILE is kept for interface
// compatibility; preloading is not performed in this build.
module fb_ram #(
  parameter int    ADDR_W    = 10,
  parameter int    DEPTH     = 1024,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Reading the array in the same edge as the write returns the old
  // contents, which gives read-first behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= 8'h00;
    else        rdata <= mem[raddr];
  end

endmodule

// File: rtl/framebuffer_arbiter.sv
// Frame buffer owner: serves the screen driver read port every cycle and
// arbitrates the single write port between the fill sequencer and two
// writer clients.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   pixelAddress/pixelData     read port, registered, 1-cycle latency
//   wrN_req/addr/data/ack      writer N (N = 0,1)
//   clear_req/clear_value      start a fill with clear_value
//   busy                       fill in progress (writers locked out)
//   clear_done                 one-cycle pulse when a fill completes
//   dbg_state                  fill sequencer state
//
// Writer handshake: wrN_req is a level held with stable addr/data until
// acked. A write commits at the rising edge where the writer is granted,
// and wrN_ack is high for exactly the following cycle. In the ack cycle
// the writer drops req or presents the next addr/data.
module framebuffer_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_W         = FB_ADDR_W,
  parameter int DEPTH          = FB_DEPTH,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pixelAddress,
  output logic [7:0]        pixelData,
  input  logic              wr0_req,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [7:0]        wr0_data,
  output logic              wr0_ack,
  input  logic              wr1_req,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [7:0]        wr1_data,
  output logic              wr1_ack,
  input  logic              clear_req,
  input  logic [7:0]        clear_value,
  output logic              busy,
  output logic              clear_done,
  output fill_state_e       dbg_state
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  fill_state_e       state;
  logic [ADDR_W-1:0] fill_addr;
  logic [7:0]        fill_value;
  logic              rr_wr1;      // 1: wr1 wins the next tie
  logic [1:0]        grant;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [7:0]        ram_wdata;

  assign dbg_state = state;

  // Writers may be granted in IDLE and DONE; FILL owns the port.
  always_comb begin
    grant = 2'b00;
    if (state != ST_FILL) begin
      if (wr0_req && wr1_req) begin
        if (rr_wr1) grant[WR1] = 1'b1;
        else        grant[WR0] = 1'b1;
      end else if (wr0_req) begin
        grant[WR0] = 1'b1;
      end else if (wr1_req) begin
        grant[WR1] = 1'b1;
      end
    end
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = fill_addr;
    ram_wdata = fill_value;
    if (state == ST_FILL) begin
      ram_we = 1'b1;
    end else if (grant[WR0]) begin
      ram_we    = 1'b1;
      ram_waddr = wr0_addr;
      ram_wdata = wr0_data;
    end else if (grant[WR1]) begin
      ram_we    = 1'b1;
      ram_waddr = wr1_addr;
      ram_wdata = wr1_data;
    end
  end

  // Fill sequencer. busy mirrors "state == FILL" but is registered so it
  // is a clean output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= CLEAR_ON_RESET ? ST_FILL : ST_IDLE;
      busy       <= CLEAR_ON_RESET;
      fill_addr  <= '0;
      fill_value <= 8'h00;
      clear_done <= 1'b0;
    end else begin
      clear_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (clear_req) begin
            fill_value <= clear_value;
            fill_addr  <= '0;
            busy       <= 1'b1;
            state      <= ST_FILL;
          end
        end
        ST_FILL: begin
          // Address holds at the last location; exactly DEPTH writes.
          if (fill_addr == LAST_ADDR) begin
            busy       <= 1'b0;
            clear_done <= 1'b1;
            state      <= ST_DONE;
          end else begin
            fill_addr <= fill_addr + 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Acks and round-robin pointer. Any grant, contested or not, moves the
  // pointer to the other writer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr0_ack <= 1'b0;
      wr1_ack <= 1'b0;
      rr_wr1  <= 1'b0;
    end else begin
      wr0_ack <= grant[WR0];
      wr1_ack <= grant[WR1];
      if (grant[WR0])      rr_wr1 <= 1'b1;
      else if (grant[WR1]) rr_wr1 <= 1'b0;
    end
  end

  fb_ram #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (pixelAddress),
    .rdata (pixelData)
  );

endmodule

// File: tb/tb_framebuffer_arbiter.sv
module tb_framebuffer_arbiter;
  import fb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [9:0]  pixelAddress = '0;
  logic [7:0]  pixelData;
  logic        wr0_req = 1'b0, wr1_req = 1'b0;
  logic [9:0]  wr0_addr = '0, wr1_addr = '0;
  logic [7:0]  wr0_data = '0, wr1_data = '0;
  logic        wr0_ack, wr1_ack;
  logic        clear_req = 1'b0;
  logic [7:0]  clear_value = '0;
  logic        busy, clear_done;
  fill_state_e dbg_state;

  framebuffer_arbiter #(.ADDR_W(10), .DEPTH(1024), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .pixelAddress(pixelAddress), .pixelData(pixelData),
    .wr0_req(wr0_req), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_ack(wr0_ack),
    .wr1_req(wr1_req), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_ack(wr1_ack),
    .clear_req(clear_req), .clear_value(clear_value),
    .busy(busy), .clear_done(clear_done), .dbg_state(dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;

  // scoreboard for the round-robin burst
  logic [7:0] exp_q[$];
  logic [9:0] addr_q[$];

  // ---------------- driver tasks ----------------
  task automatic read_byte(input logic [9:0] a, output logic [7:0] d);
    @(negedge clk);
    pixelAddress = a;
    @(negedge clk);
    d = pixelData;
  endtask

  // Called at a negedge with a fill running. Counts busy samples until busy
  // falls, then reports clear_done at that sample and at the next one.
  task automatic wait_fill(output int busy_cycles, output logic done_now,
                           output logic done_next);
    busy_cycles = 0;
    for (int i = 0; i < 2000; i++) begin
      if (!busy) break;
      busy_cycles++;
      @(negedge clk);
    end
    done_now = clear_done;
    @(negedge clk);
    done_next = clear_done;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    int bc; logic dn, dx; logic [7:0] d;
    logic [9:0] addrs [3];
    addrs = '{10'd0, 10'd511, 10'd1023};
    rst_n = 1'b0;
    #12;
    n_vec++; if (pixelData !== 8'h00) begin n_err++; $display("FAIL reset_pixelData: got %h want 00", pixelData); end
    n_vec++; if ({wr0_ack, wr1_ack, clear_done} !== 3'b000) begin n_err++; $display("FAIL reset_pulses: got %b want 000", {wr0_ack, wr1_ack, clear_done}); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL reset_busy: got %b want 1", busy); end
    n_vec++; if (dbg_state !== ST_FILL) begin n_err++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_FILL); end
    @(negedge clk);
    rst_n = 1'b1;
    wait_fill(bc, dn, dx);
    n_vec++; if (bc !== 1024) begin n_err++; $display("FAIL boot_fill_len: got %0d want 1024", bc); end
    n_vec++; if (dn !== 1'b1) begin n_err++; $display("FAIL boot_done_pulse: got %b want 1", dn); end
    n_vec++; if (dx !== 1'b0) begin n_err++; $display("FAIL boot_done_width: got %b want 0", dx); end
    for (int i = 0; i < 3; i++) begin
      read_byte(addrs[i], d);
      n_vec++; if (d !== 8'h00) begin n_err++; $display("FAIL boot_read[%0d]: got %h want 00", addrs[i], d); end
    end
  endtask

  task automatic test_single_write;
    int acks = 0; int first_at = -1; logic [7:0] d;
    @(negedge clk);
    wr0_req = 1'b1; wr0_addr = 10'd5; wr0_data = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (wr0_ack) begin
        acks++;
        if (first_at < 0) first_at = i;
        wr0_req = 1'b0;
      end
    end
    wr0_req = 1'b0;
    n_vec++; if (acks !== 1) begin n_err++; $display("FAIL single_ack_count: got %0d want 1", acks); end
    n_vec++; if (first_at !== 0) begin n_err++; $display("FAIL single_ack_latency: got %0d want 0", first_at); end
    read_byte(10'd5, d);
    n_vec++; if (d !== 8'hA5) begin n_err++; $display("FAIL single_readback: got %h want a5", d); end
  endtask

  // Last grant was wr0, so the first contested grant goes to wr1.
  task automatic test_round_robin;
    int i0 = 0, i1 = 0; logic exp_wr1 = 1'b1; logic [7:0] d, e; logic [9:0] a;
    logic [9:0] a0 [3]; logic [9:0] a1 [3]; logic [7:0] d0 [3]; logic [7:0] d1 [3];
    a0 = '{10'd100, 10'd101, 10'd102}; d0 = '{8'h10, 8'h11, 8'h12};
    a1 = '{10'd200, 10'd201, 10'd202}; d1 = '{8'h20, 8'h21, 8'h22};
    @(negedge clk);
    wr0_req = 1'b1; wr0_addr = a0[0]; wr0_data = d0[0];
    wr1_req = 1'b1; wr1_addr = a1[0]; wr1_data = d1[0];
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_vec++;
      if ({wr1_ack, wr0_ack} !== (exp_wr1 ? 2'b10 : 2'b01)) begin
        n_err++;
        $display("FAIL rr_ack[%0d]: got wr1,wr0=%b want %b", c, {wr1_ack, wr0_ack}, exp_wr1 ? 2'b10 : 2'b01);
      end
      if (wr0_ack && i0 < 3) begin
        exp_q.push_back(d0[i0]); addr_q.push_back(a0[i0]); i0++;
        if (i0 < 3) begin wr0_addr = a0[i0]; wr0_data = d0[i0]; end else wr0_req = 1'b0;
      end
      if (wr1_ack && i1 < 3) begin
        exp_q.push_back(d1[i1]); addr_q.push_back(a1[i1]); i1++;
        if (i1 < 3) begin wr1_addr = a1[i1]; wr1_data = d1[i1]; end else wr1_req = 1'b0;
      end
      exp_wr1 = ~exp_wr1;
    end
    wr0_req = 1'b0; wr1_req = 1'b0;
    n_vec++; if (exp_q.size() !== 6) begin n_err++; $display("FAIL rr_write_count: got %0d want 6", exp_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = addr_q.pop_front();
      read_byte(a, d);
      n_vec++; if (d !== e) begin n_err++; $display("FAIL rr_readback[%0d]: got %h want %h", a, d, e); end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] d;
    @(negedge clk);
    wr1_req = 1'b1; wr1_addr = 10'd400; wr1_data = 8'h40;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_vec++; if ({wr1_ack, wr0_ack} !== 2'b10) begin n_err++; $display("FAIL b2b_ack[%0d]: got wr1,wr0=%b want 10", c, {wr1_ack, wr0_ack}); end
      if (c < 2) begin wr1_addr = 10'(401 + c); wr1_data = 8'(8'h41 + c); end
      else wr1_req = 1'b0;
    end
    for (int c = 0; c < 3; c++) begin
      read_byte(10'(400 + c), d);
      n_vec++; if (d !== 8'(8'h40 + c)) begin n_err++; $display("FAIL b2b_readback[%0d]: got %h want %h", 400 + c, d, 8'(8'h40 + c)); end
    end
  endtask

  task automatic test_read_during_write;
    @(negedge clk);
    wr0_req = 1'b1; wr0_addr = 10'd7; wr0_data = 8'h3C; pixelAddress = 10'd7;
    @(negedge clk);
    n_vec++; if (pixelData !== 8'h00) begin n_err++; $display("FAIL rdw_old: got %h want 00", pixelData); end
    n_vec++; if (wr0_ack !== 1'b1) begin n_err++; $display("FAIL rdw_ack: got %b want 1", wr0_ack); end
    wr0_req = 1'b0;
    @(negedge clk);
    n_vec++; if (pixelData !== 8'h3C) begin n_err++; $display("FAIL rdw_new: got %h want 3c", pixelData); end
  endtask

  task automatic test_clear_with_pending;
    int bc = 0; int early = 0; int bad = 0; int first_bad = -1; logic [7:0] e;
    @(negedge clk);
    clear_value = 8'hFF; clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL clear_start_busy: got %b want 1", busy); end
    wr1_req = 1'b1; wr1_addr = 10'd300; wr1_data = 8'h5A;
    for (int i = 0; i < 2000; i++) begin
      if (!busy) break;
      bc++;
      if (wr1_ack) early++;
      clear_req = (i == 100);
      if (i == 100) clear_value = 8'h11;   // must be ignored mid-fill
      @(negedge clk);
    end
    clear_req = 1'b0;
    n_vec++; if (bc !== 1024) begin n_err++; $display("FAIL clear_fill_len: got %0d want 1024", bc); end
    n_vec++; if (early !== 0) begin n_err++; $display("FAIL clear_ack_while_busy: got %0d want 0", early); end
    n_vec++; if ({clear_done, wr1_ack} !== 2'b10) begin n_err++; $display("FAIL clear_done_cycle: got done,ack=%b want 10", {clear_done, wr1_ack}); end
    @(negedge clk);
    n_vec++; if ({clear_done, wr1_ack} !== 2'b01) begin n_err++; $display("FAIL clear_wr1_after: got done,ack=%b want 01", {clear_done, wr1_ack}); end
    wr1_req = 1'b0;
    // pipelined scan of the whole buffer
    pixelAddress = 10'd0;
    for (int a = 1; a <= 1024; a++) begin
      @(negedge clk);
      e = (a - 1 == 300) ? 8'h5A : 8'hFF;
      if (pixelData !== e) begin bad++; if (first_bad < 0) first_bad = a - 1; end
      if (a < 1024) pixelAddress = 10'(a);
    end
    n_vec++; if (bad !== 0) begin n_err++; $display("FAIL clear_scan: got %0d bad bytes (first at %0d) want 0", bad, first_bad); end
  endtask

  task automatic test_reset_mid_fill;
    int bc; logic dn, dx; logic [7:0] d;
    logic [9:0] addrs [4];
    addrs = '{10'd0, 10'd299, 10'd600, 10'd1023};
    @(negedge clk);
    clear_value = 8'h77; clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    repeat (300) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL midfill_busy: got %b want 1", busy); end
    n_vec++; if ({wr0_ack, wr1_ack, clear_done} !== 3'b000) begin n_err++; $display("FAIL midfill_pulses: got %b want 000", {wr0_ack, wr1_ack, clear_done}); end
    n_vec++; if (pixelData !== 8'h00) begin n_err++; $display("FAIL midfill_pixelData: got %h want 00", pixelData); end
    n_vec++; if (dbg_state !== ST_FILL) begin n_err++; $display("FAIL midfill_state: got %0d want %0d", dbg_state, ST_FILL); end
    @(negedge clk);
    rst_n = 1'b1;
    wait_fill(bc, dn, dx);
    n_vec++; if (bc !== 1024) begin n_err++; $display("FAIL refill_len: got %0d want 1024", bc); end
    n_vec++; if ({dn, dx} !== 2'b10) begin n_err++; $display("FAIL refill_done: got %b want 10", {dn, dx}); end
    for (int i = 0; i < 4; i++) begin
      read_byte(addrs[i], d);
      n_vec++; if (d !== 8'h00) begin n_err++; $display("FAIL refill_read[%0d]: got %h want 00", addrs[i], d); end
    end
  endtask

  task automatic test_reset_mid_handshake;
    int bc; logic dn, dx; logic [7:0] d;
    @(negedge clk);
    wr0_req = 1'b1; wr0_addr = 10'd20; wr0_data = 8'hEE;
    @(negedge clk);
    n_vec++; if (wr0_ack !== 1'b1) begin n_err++; $display("FAIL hs_ack: got %b want 1", wr0_ack); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (wr0_ack !== 1'b0) begin n_err++; $display("FAIL hs_ack_drop: got %b want 0", wr0_ack); end
    wr0_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_fill(bc, dn, dx);
    n_vec++; if (bc !== 1024) begin n_err++; $display("FAIL hs_fill_len: got %0d want 1024", bc); end
    read_byte(10'd20, d);
    n_vec++; if (d !== 8'h00) begin n_err++; $display("FAIL hs_read: got %h want 00", d); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_back_to_back();
    test_read_during_write();
    test_clear_with_pending();
    test_reset_mid_fill();
    test_reset_mid_handshake();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", n_vec);
    $fatal(1, "watchdog");
  end

endmodule
